// File: rtl/iir_pkg.sv
// Shared types and widths for the IIR datapath.
// Product, result and accumulator widths; MAC FSM state; sign-magnitude result.
package iir_pkg;

  localparam int PROD_W = 16;
  localparam int OUT_W  = 8;
  localparam int ACC_W  = 20;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } mac_state_t;

  typedef struct packed {
    logic [OUT_W-1:0] mag;
    logic             sign;
  } signmag8_t;

endpackage

// File: rtl/acc_to_signmag.sv
// Signed ACC_W sum -> saturated sign-magnitude OUT_W result (combinational).
// Ports: i_sum (signed sum) ; o_res (mag, sign) ; o_sat (magnitude clamped).
module acc_to_signmag
  import iir_pkg::*;
(
  input  logic signed [ACC_W-1:0] i_sum,
  output signmag8_t               o_res,
  output logic                    o_sat
);

  logic             w_neg;
  logic [ACC_W-1:0] w_abs;
  logic             w_big;

  assign w_neg = i_sum[ACC_W-1];
  assign w_abs = w_neg ? -i_sum : i_sum;
  assign w_big = |w_abs[ACC_W-1:OUT_W];

  // a negative sum is never zero, so the sign alone cannot yield minus zero
  assign o_res.mag  = w_big ? '1 : w_abs[OUT_W-1:0];
  assign o_res.sign = w_neg;
  assign o_sat      = w_big;

endmodule

// File: rtl/mac_accumulator.sv
// Sign-magnitude product accumulator; emits a saturated 8-bit sign-magnitude result per sample.
// Ports: in_* product handshake, out_* result handshake; macro OVF_SAT_EN enables overflow saturation.
module mac_accumulator
  import iir_pkg::*;
#(
  parameter int NTAPS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_sign,
  input  logic              in_ovf,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_mag,
  output logic              out_sign,
  output logic              out_sat,
  output logic              out_err
);

  localparam int TAP_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  if (ACC_W < PROD_W + 1 + $clog2(NTAPS)) begin : g_acc_w_chk
    $error("ACC_W too small for NTAPS products");
  end

  mac_state_t              r_state;
  mac_state_t              w_state_nxt;
  logic signed [ACC_W-1:0] r_acc;
  logic [TAP_W-1:0]        r_tap;
  logic [OUT_W-1:0]        r_mag;
  logic                    r_sign;
  logic                    r_sat;
  logic                    r_err;

  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_term;
  logic signed [ACC_W-1:0] w_sum;
  logic                    w_accept;
  logic                    w_close;
  signmag8_t               w_cv;
  logic                    w_cv_sat;
  signmag8_t               w_res;
  logic                    w_sat;

  assign in_ready  = (r_state == ACC);
  assign out_valid = (r_state == OUT);
  assign out_mag   = r_mag;
  assign out_sign  = r_sign;
  assign out_sat   = r_sat;
  assign out_err   = r_err;

  assign w_ext    = {{(ACC_W-PROD_W){1'b0}}, in_prod};
  assign w_term   = in_sign ? -w_ext : w_ext;
  assign w_sum    = r_acc + w_term;
  assign w_accept = in_valid & in_ready;
  // the NTAPS-th product closes the sample even without in_last
  assign w_close  = w_accept &
                    (in_last | (r_tap == TAP_W'(NTAPS - 1)));

  acc_to_signmag u_cv (
    .i_sum (w_sum),
    .o_res (w_cv),
    .o_sat (w_cv_sat)
  );

`ifdef OVF_SAT_EN
  logic r_ovf;
  logic w_ovf;
  logic w_zero;

  assign w_ovf  = r_ovf | in_ovf;
  assign w_zero = (w_sum == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_close) begin
      r_ovf <= 1'b0;
    end else if (w_accept && in_ovf) begin
      r_ovf <= 1'b1;
    end
  end

  // overflowed multiplier output: clamp, but keep an exact zero as zero
  assign w_res.mag  = w_ovf ? (w_zero ? '0 : '1) : w_cv.mag;
  assign w_res.sign = w_cv.sign;
  assign w_sat      = w_ovf | w_cv_sat;
`else
  logic w_unused_ovf;

  assign w_unused_ovf = in_ovf;
  assign w_res        = w_cv;
  assign w_sat        = w_cv_sat;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ACC: if (w_close) w_state_nxt = OUT;
      OUT: if (out_ready) w_state_nxt = ACC;
      default: w_state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACC;
      r_acc   <= '0;
      r_tap   <= '0;
      r_mag   <= '0;
      r_sign  <= 1'b0;
      r_sat   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_close) begin
        r_acc  <= '0;
        r_tap  <= '0;
        r_mag  <= w_res.mag;
        r_sign <= w_res.sign;
        r_sat  <= w_sat;
        r_err  <= ~in_last;
      end else if (w_accept) begin
        r_acc <= w_sum;
        r_tap <= r_tap + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed-vector bench for mac_accumulator.
// Hand-computed sums; honours OVF_SAT_EN for the overflow vector.
module tb_mac_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_prod;
  logic        in_sign;
  logic        in_ovf;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_mag;
  logic        out_sign;
  logic        out_sat;
  logic        out_err;

  int n_vec;
  int n_err;

  mac_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_sign   (in_sign),
    .in_ovf    (in_ovf),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mag   (out_mag),
    .out_sign  (out_sign),
    .out_sat   (out_sat),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // called at posedge+1; beat is presented for exactly one edge
  task automatic beat(input logic [15:0] p,
                      input logic s,
                      input logic o,
                      input logic l);
    in_valid = 1'b1;
    in_prod  = p;
    in_sign  = s;
    in_ovf   = o;
    in_last  = l;
    check("in_ready_beat", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_ovf   = 1'b0;
  endtask

  task automatic result(input string tag,
                        input logic [7:0] m,
                        input logic s,
                        input logic sat,
                        input logic err);
    check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_mag"}, {24'd0, out_mag}, {24'd0, m});
    check({tag, "_sgn"}, {31'd0, out_sign}, {31'd0, s});
    check({tag, "_sat"}, {31'd0, out_sat}, {31'd0, sat});
    check({tag, "_err"}, {31'd0, out_err}, {31'd0, err});
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("drain_vld", {31'd0, out_valid}, 32'd0);
    check("drain_rdy", {31'd0, in_ready}, 32'd1);
  endtask

  logic exp_sat7;

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_sign   = 1'b0;
    in_ovf    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", {31'd0, out_valid}, 32'd0);
    check("rst_rdy", {31'd0, in_ready}, 32'd1);
    check("rst_mag", {24'd0, out_mag}, 32'd0);
    check("rst_flags", {28'd0, out_sign, out_sat, out_err, 1'b0}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: 0x10 + 0x20 - 0x05 = 0x2B
    beat(16'h0010, 1'b0, 1'b0, 1'b0);
    beat(16'h0020, 1'b0, 1'b0, 1'b0);
    check("t1_mid_vld", {31'd0, out_valid}, 32'd0);
    beat(16'h0005, 1'b1, 1'b0, 1'b1);
    result("t1", 8'h2B, 1'b0, 1'b0, 1'b0);
    check("t1_rdy", {31'd0, in_ready}, 32'd0);
    drain();

    // 2: -0x100 - 0x80 = -0x180 -> clamp
    beat(16'h0100, 1'b1, 1'b0, 1'b0);
    beat(16'h0080, 1'b1, 1'b0, 1'b1);
    result("t2", 8'hFF, 1'b1, 1'b1, 1'b0);
    drain();

    // 3: +0x40 - 0x40 = 0, no minus zero
    beat(16'h0040, 1'b0, 1'b0, 1'b0);
    beat(16'h0040, 1'b1, 1'b0, 1'b1);
    result("t3", 8'h00, 1'b0, 1'b0, 1'b0);
    drain();

    // 4: backpressure with in_valid held high
    beat(16'h0007, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_prod  = 16'h0050;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("t4_rdy", {31'd0, in_ready}, 32'd0);
      check("t4_mag", {24'd0, out_mag}, 32'h07);
      check("t4_vld", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("t4_rdy_after", {31'd0, in_ready}, 32'd1);
    beat(16'h0002, 1'b0, 1'b0, 1'b1);
    result("t4_next", 8'h02, 1'b0, 1'b0, 1'b0);
    drain();

    // 5: tap-count close
    for (int i = 0; i < 5; i++) begin
      beat(16'h0001, 1'b0, 1'b0, 1'b0);
    end
    result("t5", 8'h05, 1'b0, 1'b0, 1'b1);
    drain();
    beat(16'h0004, 1'b0, 1'b0, 1'b1);
    result("t5_next", 8'h04, 1'b0, 1'b0, 1'b0);
    drain();

    // 6: async reset discards partial sum and clears held outputs
    beat(16'h0009, 1'b0, 1'b0, 1'b0);
    beat(16'h0009, 1'b0, 1'b0, 1'b0);
    check("t6_pre_mag", {24'd0, out_mag}, 32'h04);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_mag", {24'd0, out_mag}, 32'd0);
    check("t6_rst_vld", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(16'h0003, 1'b0, 1'b0, 1'b1);
    result("t6", 8'h03, 1'b0, 1'b0, 1'b0);
    drain();

    // 7: overflow flag with a zero sum
`ifdef OVF_SAT_EN
    exp_sat7 = 1'b1;
`else
    exp_sat7 = 1'b0;
`endif
    beat(16'h0100, 1'b0, 1'b1, 1'b0);
    beat(16'h0100, 1'b1, 1'b0, 1'b1);
    result("t7", 8'h00, 1'b0, exp_sat7, 1'b0);
    drain();

    // 8: single-term negative sample, in range
    beat(16'h0033, 1'b1, 1'b0, 1'b1);
    result("t8", 8'h33, 1'b1, 1'b0, 1'b0);
    drain();

    // 9: exact 0xFF boundary is not saturated, 0x100 is
    beat(16'h00FF, 1'b0, 1'b0, 1'b1);
    result("t9a", 8'hFF, 1'b0, 1'b0, 1'b0);
    drain();
    beat(16'h00FF, 1'b0, 1'b0, 1'b0);
    beat(16'h0001, 1'b0, 1'b0, 1'b1);
    result("t9b", 8'hFF, 1'b0, 1'b1, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
